// File: rtl/pattern_unlock_ctrl.sv
// Serial pattern unlock controller: synchronizes and deglitches an external
// bit clock, compares a frame against PATTERN and enforces a fail lockout.
`timescale 1ns/1ps
module pattern_unlock_ctrl #(
  parameter int unsigned             PATTERN_LEN    = 64,
  parameter logic [PATTERN_LEN-1:0]  PATTERN        = 64'h574AB5DEED517984,
  parameter int unsigned             STABLE_CYCLES  = 4,
  parameter int unsigned             TIMEOUT_CYCLES = 1000000,
  parameter int unsigned             MAX_FAILS      = 3,
  parameter int unsigned             LOCKOUT_CYCLES = 12000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       dataIn,
  input  logic       dataClk,
  input  logic       dataEn,
  output logic       matched,
  output logic       locked,
  output logic [3:0] failCount,
  output logic       ledR,
  output logic       ledG,
  output logic       ledB
);

  localparam int unsigned STB_W = $clog2(STABLE_CYCLES + 1);
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned LCK_W = $clog2(LOCKOUT_CYCLES + 1);
  // Padded so an 8-bit bit counter can index it without width games.
  localparam logic [255:0] PAT_EXT = 256'(PATTERN);

  typedef enum logic [2:0] {
    ST_IDLE, ST_RECEIVE, ST_CHECK, ST_MATCHED, ST_FAIL, ST_LOCKOUT
  } state_t;

  state_t             state_q;
  logic               din_m_q, din_s_q;
  logic               dclk_m_q, dclk_s_q;
  logic               den_m_q, den_s_q;
  logic               dclk_f_q, dclk_f_prev_q;
  logic [STB_W-1:0]   stb_cnt_q;
  logic [TMO_W-1:0]   tmo_cnt_q;
  logic [LCK_W-1:0]   lck_cnt_q;
  logic [7:0]         bit_cnt_q;
  logic               mismatch_q;
  logic               armed_q;
  logic               matched_q, locked_q;
  logic [3:0]         fail_cnt_q;

  logic               strobe;
  logic               bit_mis;
  logic [7:0]         bit_cnt_d;
  logic [3:0]         fail_cnt_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      din_m_q  <= 1'b0;
      din_s_q  <= 1'b0;
      dclk_m_q <= 1'b0;
      dclk_s_q <= 1'b0;
      den_m_q  <= 1'b1;
      den_s_q  <= 1'b1;
    end else begin
      din_m_q  <= dataIn;
      din_s_q  <= din_m_q;
      dclk_m_q <= dataClk;
      dclk_s_q <= dclk_m_q;
      den_m_q  <= dataEn;
      den_s_q  <= den_m_q;
    end
  end

  // dClk_f follows dClk_s only after STABLE_CYCLES consecutive differing cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      dclk_f_q      <= 1'b0;
      dclk_f_prev_q <= 1'b0;
      stb_cnt_q     <= '0;
    end else begin
      dclk_f_prev_q <= dclk_f_q;
      if (dclk_s_q == dclk_f_q) begin
        stb_cnt_q <= '0;
      end else if (stb_cnt_q == STB_W'(STABLE_CYCLES - 1)) begin
        dclk_f_q  <= dclk_s_q;
        stb_cnt_q <= '0;
      end else begin
        stb_cnt_q <= stb_cnt_q + 1'b1;
      end
    end
  end

  assign strobe     = dclk_f_q & ~dclk_f_prev_q;
  assign bit_mis    = din_s_q != PAT_EXT[bit_cnt_q];
  assign bit_cnt_d  = bit_cnt_q + 8'd1;
  assign fail_cnt_d = (fail_cnt_q == 4'd15) ? 4'd15 : fail_cnt_q + 4'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      matched_q  <= 1'b0;
      locked_q   <= 1'b0;
      fail_cnt_q <= '0;
      bit_cnt_q  <= '0;
      mismatch_q <= 1'b0;
      tmo_cnt_q  <= '0;
      lck_cnt_q  <= '0;
      armed_q    <= 1'b0;
    end else begin
      case (state_q)
        // armed_q means dEn_s was seen high in this state, so only a genuine
        // fall (not a level left low by a failed frame) starts a new frame.
        ST_IDLE, ST_MATCHED: begin
          armed_q <= den_s_q;
          if (armed_q && !den_s_q) begin
            state_q    <= ST_RECEIVE;
            bit_cnt_q  <= '0;
            mismatch_q <= 1'b0;
            tmo_cnt_q  <= '0;
            matched_q  <= 1'b0;
            armed_q    <= 1'b0;
          end
        end
        ST_RECEIVE: begin
          armed_q <= 1'b0;
          if (strobe) begin
            mismatch_q <= mismatch_q | bit_mis;
            bit_cnt_q  <= bit_cnt_d;
            tmo_cnt_q  <= '0;
          end else begin
            tmo_cnt_q  <= tmo_cnt_q + 1'b1;
          end
          // A strobe coinciding with dEn_s rising is counted before the abort.
          if (strobe && bit_cnt_d == 8'(PATTERN_LEN)) begin
            state_q <= ST_CHECK;
          end else if (den_s_q) begin
            state_q <= ST_FAIL;
          end else if (!strobe && tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
            state_q <= ST_FAIL;
          end
        end
        ST_CHECK: begin
          armed_q <= 1'b0;
          if (mismatch_q) begin
            state_q <= ST_FAIL;
          end else begin
            state_q    <= ST_MATCHED;
            matched_q  <= 1'b1;
            fail_cnt_q <= '0;
          end
        end
        ST_FAIL: begin
          armed_q    <= 1'b0;
          fail_cnt_q <= fail_cnt_d;
          if (fail_cnt_d >= 4'(MAX_FAILS)) begin
            state_q   <= ST_LOCKOUT;
            locked_q  <= 1'b1;
            lck_cnt_q <= '0;
          end else begin
            state_q   <= ST_IDLE;
          end
        end
        ST_LOCKOUT: begin
          armed_q <= 1'b0;
          if (lck_cnt_q == LCK_W'(LOCKOUT_CYCLES - 1)) begin
            state_q    <= ST_IDLE;
            locked_q   <= 1'b0;
            fail_cnt_q <= '0;
            lck_cnt_q  <= '0;
          end else begin
            lck_cnt_q  <= lck_cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          armed_q <= 1'b0;
        end
      endcase
    end
  end

  assign matched   = matched_q;
  assign locked    = locked_q;
  assign failCount = fail_cnt_q;
  assign ledR      = ~matched_q;
  assign ledG      = matched_q;
  assign ledB      = locked_q;

endmodule

// File: tb/tb_pattern_unlock_ctrl.sv
// Directed bench for pattern_unlock_ctrl using the reduced verification parameters.
`timescale 1ns/1ps
module tb_pattern_unlock_ctrl;

  logic       clk;
  logic       rst;
  logic       dataIn;
  logic       dataClk;
  logic       dataEn;
  logic       matched;
  logic       locked;
  logic [3:0] failCount;
  logic       ledR, ledG, ledB;

  int n_tests = 0;
  int n_fail  = 0;

  pattern_unlock_ctrl #(
    .PATTERN_LEN    (8),
    .PATTERN        (8'hA5),
    .STABLE_CYCLES  (3),
    .TIMEOUT_CYCLES (50),
    .MAX_FAILS      (3),
    .LOCKOUT_CYCLES (100)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .dataIn    (dataIn),
    .dataClk   (dataClk),
    .dataEn    (dataEn),
    .matched   (matched),
    .locked    (locked),
    .failCount (failCount),
    .ledR      (ledR),
    .ledG      (ledG),
    .ledB      (ledB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bits(input logic [7:0] bits, input int n, input int half);
    for (int i = 0; i < n; i++) begin
      dataIn  = bits[i];
      dataClk = 1'b1;
      tick(half);
      dataClk = 1'b0;
      tick(half);
    end
  endtask

  task automatic frame(input logic [7:0] bits, input int n, input int half);
    dataEn = 1'b0;
    tick(3);
    send_bits(bits, n, half);
    dataEn = 1'b1;
    tick(5);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; dataIn = 1'b0; dataClk = 1'b0; dataEn = 1'b1;
    tick(3);
    check("rst_matched", 32'(matched), 32'd0);
    check("rst_locked",  32'(locked),  32'd0);
    check("rst_fails",   32'(failCount), 32'd0);
    check("rst_ledR",    32'(ledR), 32'd1);
    check("rst_ledG",    32'(ledG), 32'd0);
    check("rst_ledB",    32'(ledB), 32'd0);
    rst = 1'b0;
    tick(3);

    // Good frame, exact match latency on the 8th bit.
    dataEn = 1'b0;
    tick(3);
    send_bits(8'hA5, 7, 10);
    dataIn = 1'b1; dataClk = 1'b1;
    tick(6);
    check("good_early", 32'(matched), 32'd0);
    tick(1);
    check("good_matched", 32'(matched), 32'd1);
    check("good_ledG",    32'(ledG), 32'd1);
    check("good_ledR",    32'(ledR), 32'd0);
    check("good_fails",   32'(failCount), 32'd0);
    tick(3);
    dataClk = 1'b0;
    tick(10);
    send_bits(8'h00, 1, 10);
    check("extra_bit_matched", 32'(matched), 32'd1);
    dataEn = 1'b1;
    tick(5);

    // Bit 3 flipped: frame runs to its full length before failing.
    dataEn = 1'b0;
    tick(3);
    send_bits(8'hAD, 7, 10);
    check("bad_mid_matched", 32'(matched), 32'd0);
    check("bad_mid_fails",   32'(failCount), 32'd0);
    send_bits(8'h01, 1, 10);
    check("bad_fails", 32'(failCount), 32'd1);
    dataEn = 1'b1;
    tick(5);
    check("bad_ledR", 32'(ledR), 32'd1);

    // Glitches mid-frame must not count as bits.
    dataEn = 1'b0;
    tick(3);
    send_bits(8'hA5, 3, 10);
    dataClk = 1'b1; tick(2); dataClk = 1'b0; tick(4);
    for (int i = 0; i < 3; i++) begin
      dataClk = 1'b1; tick(1); dataClk = 1'b0; tick(2);
    end
    tick(4);
    check("glitch_bitcnt", 32'(dut.bit_cnt_q), 32'd3);
    send_bits(8'h14, 5, 10);
    check("glitch_matched", 32'(matched), 32'd1);
    check("glitch_fails",   32'(failCount), 32'd0);
    dataEn = 1'b1;
    tick(5);

    // Short frame, timeout frame, bad frame -> lockout.
    frame(8'hA5, 5, 10);
    check("short_fails",   32'(failCount), 32'd1);
    check("short_matched", 32'(matched), 32'd0);
    dataEn = 1'b0;
    tick(45);
    check("tmo_early_fails", 32'(failCount), 32'd1);
    tick(25);
    check("tmo_fails", 32'(failCount), 32'd2);
    dataEn = 1'b1;
    tick(5);
    frame(8'hAD, 8, 10);
    check("lock_locked", 32'(locked), 32'd1);
    check("lock_ledB",   32'(ledB), 32'd1);
    check("lock_fails",  32'(failCount), 32'd3);
    frame(8'hA5, 8, 4);
    check("lock_ignored_matched", 32'(matched), 32'd0);
    check("lock_still_locked",    32'(locked), 32'd1);
    tick(20);
    check("unlock_locked", 32'(locked), 32'd0);
    check("unlock_fails",  32'(failCount), 32'd0);
    check("unlock_ledB",   32'(ledB), 32'd0);

    // Reset during the 4th bit clears everything, then a clean frame matches.
    frame(8'hA5, 5, 10);
    check("pre_rst_fails", 32'(failCount), 32'd1);
    dataEn = 1'b0;
    tick(3);
    send_bits(8'hA5, 3, 10);
    dataIn = 1'b0; dataClk = 1'b1;
    tick(4);
    rst = 1'b1; dataEn = 1'b1; dataClk = 1'b0;
    tick(2);
    check("midrst_fails",   32'(failCount), 32'd0);
    check("midrst_matched", 32'(matched), 32'd0);
    check("midrst_locked",  32'(locked), 32'd0);
    rst = 1'b0;
    tick(5);
    check("midrst_bitcnt", 32'(dut.bit_cnt_q), 32'd0);
    frame(8'hA5, 8, 10);
    check("post_rst_matched", 32'(matched), 32'd1);
    check("post_rst_fails",   32'(failCount), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
